// File: rtl/ham_15_11_enc_stream.sv
// Streaming Hamming (15,11) SEC encoder.
// Words enter on a valid/ready port, are encoded (with optional single-bit
// fault injection) and queued in a 2-entry FIFO that feeds the downstream
// valid/ready port. All outputs come straight from flops.

// Combinational (15,11) encoder with a single-bit fault-injection hook.
module ham_15_11_enc_core (
    input  logic [10:0] data,
    input  logic [3:0]  inj_pos,
    output logic [14:0] cw,
    output logic        inj
);
    logic [14:0] base;
    logic [14:0] flip;

    // Place data bits at non-power-of-two positions, then fill the parity slots.
    always_comb begin
        base       = '0;
        base[2]    = data[0];
        base[6:4]  = data[3:1];
        base[14:8] = data[10:4];
        base[0]    = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6] ^ data[8] ^ data[10];
        base[1]    = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6] ^ data[9] ^ data[10];
        base[3]    = data[1] ^ data[2] ^ data[3] ^ data[7] ^ data[8] ^ data[9] ^ data[10];
        base[7]    = data[4] ^ data[5] ^ data[6] ^ data[7] ^ data[8] ^ data[9] ^ data[10];
    end

    // Position k (1..15) flips codeword bit k-1; position 0 leaves it intact.
    always_comb begin
        flip = '0;
        if (inj_pos != 4'd0)
            flip = 15'd1 << (inj_pos - 4'd1);
    end

    assign cw  = base ^ flip;
    assign inj = (inj_pos != 4'd0);
endmodule

module ham_15_11_enc_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [10:0]      data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       inj_pos_i,
    output logic [14:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             inj_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [CNT_W-1:0] inj_cnt_o
);
    typedef struct packed {
        logic        inj;
        logic [14:0] cw;
    } entry_t;

    entry_t     mem [2];
    entry_t     mem_n [2];
    entry_t     new_entry;
    entry_t     head_q;
    entry_t     head_n;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       rd_ptr_n;
    logic [1:0] count;
    logic [1:0] count_n;
    logic       push;
    logic       pop;

    ham_15_11_enc_core u_enc (
        .data    (data_i),
        .inj_pos (inj_pos_i),
        .cw      (new_entry.cw),
        .inj     (new_entry.inj)
    );

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    // Next occupancy, read pointer and head entry; the head only changes
    // when the FIFO stays non-empty, so data_o/inj_o hold while idle.
    always_comb begin
        count_n = count;
        unique case ({push, pop})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase
        rd_ptr_n = rd_ptr ^ pop;
        mem_n    = mem;
        if (push)
            mem_n[wr_ptr] = new_entry;
        head_n = head_q;
        if (count_n != 2'd0)
            head_n = mem_n[rd_ptr_n];
    end

    // FIFO storage, pointers and registered handshake flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            head_q  <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            if (push)
                mem[wr_ptr] <= new_entry;
            wr_ptr  <= wr_ptr ^ push;
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            head_q  <= head_n;
            ready_o <= (count_n != 2'd2);
            valid_o <= (count_n != 2'd0);
        end
    end

    // Free-running accepted-word and injected-word counters (wrap, no saturation).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt_o <= '0;
            inj_cnt_o  <= '0;
        end else if (push) begin
            word_cnt_o <= word_cnt_o + CNT_W'(1);
            if (new_entry.inj)
                inj_cnt_o <= inj_cnt_o + CNT_W'(1);
        end
    end

    assign data_o = head_q.cw;
    assign inj_o  = head_q.inj;
endmodule

// File: tb/tb_ham_15_11_enc_stream.sv
// Bench for ham_15_11_enc_stream: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed codewords.
module tb_ham_15_11_enc_stream;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [10:0]      data_i;
    logic             valid_i;
    logic             ready_o;
    logic [3:0]       inj_pos_i;
    logic [14:0]      data_o;
    logic             valid_o;
    logic             ready_i;
    logic             inj_o;
    logic [CNT_W-1:0] word_cnt_o;
    logic [CNT_W-1:0] inj_cnt_o;

    int compared   = 0;
    int mismatched = 0;

    ham_15_11_enc_stream #(.CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .inj_pos_i  (inj_pos_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .inj_o      (inj_o),
        .word_cnt_o (word_cnt_o),
        .inj_cnt_o  (inj_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Generic Hamming construction: data fills non-power-of-two positions in
    // order, parity at position 2^i covers every position with bit i set.
    function automatic logic [15:0] model_enc(input logic [10:0] d, input logic [3:0] pos);
        logic [14:0] cw;
        int k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        for (int i = 0; i < 4; i++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p <= 15; p++)
                if (((p & (p - 1)) != 0) && (((p >> i) & 1) == 1))
                    par ^= cw[p-1];
            cw[(1 << i) - 1] = par;
        end
        if (pos != 4'd0)
            cw[pos-1] = ~cw[pos-1];
        return {(pos != 4'd0), cw};
    endfunction

    // Syndrome decoder: XOR of set-bit positions names the flipped bit.
    function automatic logic [10:0] model_dec(input logic [14:0] cw_in);
        logic [14:0] cw;
        logic [3:0]  syn;
        logic [10:0] d;
        int k;
        cw  = cw_in;
        syn = '0;
        for (int p = 1; p <= 15; p++)
            if (cw[p-1]) syn ^= 4'(p);
        if (syn != 4'd0) cw[syn-1] = ~cw[syn-1];
        k = 0;
        d = '0;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin
                d[k] = cw[p-1];
                k++;
            end
        return d;
    endfunction

    // Reference model state.
    logic [15:0] q[$];
    int          m_wc;
    int          m_ic;
    logic [15:0] shown;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q.delete();
            m_wc  = 0;
            m_ic  = 0;
            shown = '0;
        end else begin
            bit push, pop;
            push = (valid_i === 1'b1) && (q.size() < 2);
            pop  = (q.size() > 0) && (ready_i === 1'b1);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(model_enc(data_i, inj_pos_i));
                m_wc = (m_wc + 1) % (1 << CNT_W);
                if (inj_pos_i != 4'd0) m_ic = (m_ic + 1) % (1 << CNT_W);
            end
            if (q.size() > 0) shown = q[0];
        end
    end

    // Per-cycle compare and output log.
    logic [14:0] out_log[$];
    bit          seen15 = 0;

    always @(negedge clk_i) begin
        check("valid_o", 32'(valid_o), 32'(q.size() != 0));
        check("ready_o", 32'(ready_o), 32'(q.size() != 2));
        check("data_o",  32'(data_o),  32'(shown[14:0]));
        check("inj_o",   32'(inj_o),   32'(shown[15]));
        check("word_cnt_o", 32'(word_cnt_o), 32'(m_wc));
        check("inj_cnt_o",  32'(inj_cnt_o),  32'(m_ic));
        if (valid_o === 1'b1 && ready_i === 1'b1 && rst_i === 1'b0)
            out_log.push_back(data_o);
        if (word_cnt_o === 4'd15) seen15 = 1;
    end

    task automatic send(input logic [10:0] d, input logic [3:0] pos);
        bit ok;
        ok = 0;
        @(negedge clk_i);
        valid_i   = 1'b1;
        data_i    = d;
        inj_pos_i = pos;
        for (int n = 0; n < 50; n++) begin
            if (ready_o === 1'b1) begin
                @(posedge clk_i);
                ok = 1;
                break;
            end
            @(negedge clk_i);
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: word %h never accepted", d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            valid_i   = 1'b0;
            data_i    = 'x;
            inj_pos_i = 'x;
        end
    endtask

    initial begin
        logic [15:0] e;
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        data_i    = '0;
        inj_pos_i = '0;

        // Pin the model with hand-computed codewords.
        e = model_enc(11'h001, 4'd0); check("model_001", 32'(e), 32'h0007);
        e = model_enc(11'h7FF, 4'd0); check("model_7ff", 32'(e), 32'h7FFF);
        e = model_enc(11'h400, 4'd0); check("model_400", 32'(e), 32'h408B);
        e = model_enc(11'h001, 4'd3); check("model_inj3", 32'(e), 32'h8003);
        check("model_dec", 32'(model_dec(15'h0003)), 32'h001);

        #12;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data",  32'(data_o),  32'd0);
        check("rst_wcnt",  32'(word_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // 1: single word, latency one clock.
        send(11'h001, 4'd0);
        idle(1);
        check("t1_valid", 32'(valid_o), 32'd1);
        check("t1_data",  32'(data_o),  32'h0007);
        check("t1_inj",   32'(inj_o),   32'd0);
        check("t1_wcnt",  32'(word_cnt_o), 32'd1);
        ready_i = 1'b1;
        idle(3);

        // 2: back-to-back at full rate.
        out_log.delete();
        send(11'h000, 4'd0);
        send(11'h7FF, 4'd0);
        send(11'h400, 4'd0);
        idle(4);
        check("t2_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            check("t2_w0", 32'(out_log[0]), 32'h0000);
            check("t2_w1", 32'(out_log[1]), 32'h7FFF);
            check("t2_w2", 32'(out_log[2]), 32'h408B);
        end

        // 3: backpressure with three offered words.
        out_log.delete();
        @(negedge clk_i);
        ready_i = 1'b0;
        fork
            begin
                send(11'h123, 4'd0);
                send(11'h456, 4'd0);
                send(11'h789, 4'd0);
            end
            begin
                repeat (4) @(negedge clk_i);
                check("t3_full", 32'(ready_o), 32'd0);
                ready_i = 1'b1;
            end
        join
        idle(5);
        check("t3_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            e = model_enc(11'h123, 4'd0); check("t3_w0", 32'(out_log[0]), 32'(e[14:0]));
            e = model_enc(11'h456, 4'd0); check("t3_w1", 32'(out_log[1]), 32'(e[14:0]));
            e = model_enc(11'h789, 4'd0); check("t3_w2", 32'(out_log[2]), 32'(e[14:0]));
        end

        // 4: fault injection at position 3.
        ready_i = 1'b0;
        send(11'h001, 4'd3);
        idle(1);
        check("t4_data", 32'(data_o), 32'h0003);
        check("t4_inj",  32'(inj_o),  32'd1);
        check("t4_icnt", 32'(inj_cnt_o), 32'd1);
        check("t4_dec",  32'(model_dec(data_o)), 32'h001);
        ready_i = 1'b1;
        idle(3);

        // 5: asynchronous reset with two words buffered.
        ready_i = 1'b0;
        send(11'h055, 4'd0);
        send(11'h2AA, 4'd5);
        idle(1);
        #2 rst_i = 1'b1;
        #1;
        check("t5_valid", 32'(valid_o), 32'd0);
        check("t5_ready", 32'(ready_o), 32'd1);
        check("t5_wcnt",  32'(word_cnt_o), 32'd0);
        check("t5_icnt",  32'(inj_cnt_o),  32'd0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        out_log.delete();
        idle(4);
        check("t5_nostale", 32'(out_log.size()), 32'd0);

        // 6: counter wrap with 17 accepted words.
        seen15 = 0;
        for (int i = 0; i < 17; i++)
            send(11'(i * 37), 4'd0);
        idle(3);
        check("t6_seen15", 32'(seen15), 32'd1);
        check("t6_wcnt",   32'(word_cnt_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
